// File: rtl/resnet_stream_sequencer.sv
// Run-level sequencer for the resnet accelerator stream ports: flush, route the shared
// source stream into the kernel port then the input port, then count output strobes.
module resnet_stream_sequencer #(
    parameter int DATA_W        = 16,
    parameter int KERNEL_WORDS  = 9,
    parameter int INPUT_WORDS   = 64,
    parameter int OUTPUT_WORDS  = 49,
    parameter int CNT_W         = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              flush,
    output logic              kernel_read_en,
    output logic [DATA_W-1:0] kernel_data,
    output logic              input_read_en,
    output logic [DATA_W-1:0] input_data,
    input  logic              out_write_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(KERNEL_WORDS - 1);
    localparam logic [CNT_W-1:0] I_LAST  = CNT_W'(INPUT_WORDS - 1);
    localparam logic [CNT_W-1:0] O_MAX   = CNT_W'(OUTPUT_WORDS);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(DRAIN_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        LOAD_K = 3'd2,
        LOAD_I = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  word_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              xfer;
    logic              last_word;
    logic              out_full;
    logic              tmo_hit;
    logic              counting;
    logic              accept_start;

    assign src_ready    = (state == LOAD_K) || (state == LOAD_I);
    assign busy         = (state != IDLE);
    assign xfer         = src_valid & src_ready;
    assign last_word    = (state == LOAD_K) ? (word_cnt == K_LAST) : (word_cnt == I_LAST);
    assign out_full     = (out_count == O_MAX);
    assign counting     = (state == FLUSH) || (state == LOAD_K) || (state == LOAD_I) || (state == DRAIN);
    assign accept_start = (state == IDLE) && start;
    // The idle count is compared after this cycle's increment, so DONE follows the
    // DRAIN_TIMEOUT-th consecutive idle cycle directly.
    assign tmo_hit      = (state == DRAIN) && !out_write_valid &&
                          ((tmo_cnt + TMO_W'(1)) == TMO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FLUSH;
            FLUSH:   state_next = LOAD_K;
            LOAD_K:  if (xfer && last_word) state_next = LOAD_I;
            LOAD_I:  if (xfer && last_word) state_next = DRAIN;
            DRAIN:   if (out_full || tmo_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush          <= 1'b0;
            done           <= 1'b0;
            kernel_read_en <= 1'b0;
            kernel_data    <= '0;
            input_read_en  <= 1'b0;
            input_data     <= '0;
            word_cnt       <= '0;
            tmo_cnt        <= '0;
            out_count      <= '0;
            error          <= 1'b0;
        end else begin
            flush          <= (state_next == FLUSH);
            done           <= (state_next == DONE);
            kernel_read_en <= xfer && (state == LOAD_K);
            input_read_en  <= xfer && (state == LOAD_I);
            if (xfer && (state == LOAD_K)) kernel_data <= src_data;
            if (xfer && (state == LOAD_I)) input_data  <= src_data;

            if (state == IDLE) begin
                word_cnt <= '0;
            end else if (xfer) begin
                word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
            end

            if ((state != DRAIN) || out_write_valid) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (accept_start) begin
                out_count <= '0;
            end else if (counting && out_write_valid && !out_full) begin
                out_count <= out_count + CNT_W'(1);
            end

            // Later assignments win: a fault in the same cycle as an accepted start stays flagged.
            if (accept_start) error <= 1'b0;
            if (out_write_valid && ((state == IDLE) || (state == DONE))) error <= 1'b1;
            if (out_write_valid && counting && out_full) error <= 1'b1;
            if (tmo_hit && !out_full) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_resnet_stream_sequencer.sv
// Directed-sequence bench for resnet_stream_sequencer: random source words, stream contents,
// strobe counts and done/error timing are checked against expectations built here.
module tb_resnet_stream_sequencer;

    localparam int KW  = 9;
    localparam int IW  = 64;
    localparam int OW  = 49;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_ready;
    logic        flush;
    logic        kernel_read_en;
    logic [15:0] kernel_data;
    logic        input_read_en;
    logic [15:0] input_data;
    logic        out_write_valid;
    logic [15:0] out_count;
    logic        busy;
    logic        done;
    logic        error;

    resnet_stream_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .flush           (flush),
        .kernel_read_en  (kernel_read_en),
        .kernel_data     (kernel_data),
        .input_read_en   (input_read_en),
        .input_data      (input_data),
        .out_write_valid (out_write_valid),
        .out_count       (out_count),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Observed streams and event counters, collected on the falling edge.
    logic [15:0] kq[$];
    logic [15:0] iq[$];
    int          flush_cnt, done_cnt, done_cyc, strobe_cyc, excl_err, hold_k, hold_i, cyc;
    logic [15:0] last_k, last_i;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (kernel_read_en) kq.push_back(kernel_data);
        else if (rst_n && kernel_data !== last_k) hold_k <= hold_k + 1;
        if (input_read_en) iq.push_back(input_data);
        else if (rst_n && input_data !== last_i) hold_i <= hold_i + 1;
        last_k <= kernel_data;
        last_i <= input_data;
        if (kernel_read_en && input_read_en) excl_err <= excl_err + 1;
        if (flush) flush_cnt <= flush_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (out_write_valid) strobe_cyc <= cyc;
    end

    // Source producer: offers the head of src_q, optionally on alternate cycles only.
    logic [15:0] src_q[$];
    bit          tog_mode;
    bit          tog;
    bit          acc;

    always begin
        @(negedge clk);
        acc = src_valid && src_ready;
        @(posedge clk);
        #1;
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        tog = !tog;
        src_valid = (src_q.size() > 0) && (!tog_mode || tog);
        src_data  = (src_q.size() > 0) ? src_q[0] : 16'($urandom);
    end

    logic [15:0] sent[KW+IW];
    int          kbase, ibase, fbase, dbase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input string run, input bit toggle);
        tog_mode = toggle;
        for (int i = 0; i < KW + IW; i++) begin
            sent[i] = 16'($urandom);
            src_q.push_back(sent[i]);
        end
        kbase = kq.size();
        ibase = iq.size();
        fbase = flush_cnt;
        dbase = done_cnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk({run, "_error_cleared"}, 32'(error), 0);
        chk({run, "_busy"}, 32'(busy), 1);
        chk({run, "_flush"}, 32'(flush), 1);
    endtask

    task automatic wait_strobes(input string tag, input bit inp, input int n, input int limit);
        int got;
        got = 0;
        for (int i = 0; i < limit; i++) begin
            got = inp ? iq.size() - ibase : kq.size() - kbase;
            if (got >= n) break;
            tick(1);
        end
        got = inp ? iq.size() - ibase : kq.size() - kbase;
        chk(tag, got, n);
    endtask

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            out_write_valid = 1'b1;
            tick(1);
            out_write_valid = 1'b0;
            tick(gap);
        end
    endtask

    task automatic finish_run(input string run, input int exp_oc, input int exp_err);
        int bad;
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt != dbase) break;
            tick(1);
        end
        tick(3);
        chk({run, "_done_pulses"}, done_cnt - dbase, 1);
        chk({run, "_flush_pulses"}, flush_cnt - fbase, 1);
        chk({run, "_kernel_words"}, kq.size() - kbase, KW);
        chk({run, "_input_words"}, iq.size() - ibase, IW);
        bad = 0;
        for (int i = 0; i < KW; i++)
            if (kbase + i >= kq.size() || kq[kbase + i] !== sent[i]) bad++;
        chk({run, "_kernel_data_errs"}, bad, 0);
        bad = 0;
        for (int i = 0; i < IW; i++)
            if (ibase + i >= iq.size() || iq[ibase + i] !== sent[KW + i]) bad++;
        chk({run, "_input_data_errs"}, bad, 0);
        chk({run, "_out_count"}, 32'(out_count), exp_oc);
        chk({run, "_error"}, 32'(error), exp_err);
        chk({run, "_busy_after"}, 32'(busy), 0);
        chk({run, "_read_en_overlap"}, excl_err, 0);
        chk({run, "_data_hold"}, hold_k + hold_i, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_flags"}, 32'({src_ready, flush, kernel_read_en, input_read_en, busy, done, error}), 0);
        chk({tag, "_data"}, {kernel_data, input_data}, 0);
        chk({tag, "_out_count"}, 32'(out_count), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_write_valid = 1'b0;
        tick(2);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        tick(2);

        // Nominal run.
        start_run("nominal", 1'b0);
        wait_strobes("nominal_kernel_wait", 1'b0, KW, 100);
        wait_strobes("nominal_input_wait", 1'b1, IW, 200);
        pulses(OW, 1);
        finish_run("nominal", OW, 0);

        // Source valid toggling every cycle.
        start_run("backpressure", 1'b1);
        wait_strobes("bp_kernel_wait", 1'b0, KW, 200);
        wait_strobes("bp_input_wait", 1'b1, IW, 400);
        pulses(OW, int'($urandom_range(0, 3)));
        finish_run("backpressure", OW, 0);

        // Output strobes arriving while the input stream is still loading.
        start_run("early", 1'b0);
        wait_strobes("early_kernel_wait", 1'b0, KW, 100);
        pulses(20, 0);
        wait_strobes("early_input_wait", 1'b1, IW, 200);
        chk("early_count_at_drain", 32'(out_count), 20);
        pulses(OW - 20, 1);
        finish_run("early", OW, 0);

        // Too few outputs: timeout abort.
        start_run("timeout", 1'b0);
        wait_strobes("to_kernel_wait", 1'b0, KW, 100);
        wait_strobes("to_input_wait", 1'b1, IW, 200);
        pulses(10, 2);
        finish_run("timeout", 10, 1);
        // done rises DRAIN_TIMEOUT clock edges after the edge that sampled the last strobe.
        chk("timeout_latency", done_cyc - strobe_cyc - 1, TMO);

        // One strobe beyond the expected total.
        start_run("overrun", 1'b0);
        wait_strobes("ov_kernel_wait", 1'b0, KW, 100);
        wait_strobes("ov_input_wait", 1'b1, IW, 200);
        pulses(OW + 1, 0);
        finish_run("overrun", OW, 1);

        // Start pulses while busy must not restart the run.
        start_run("start_busy", 1'b0);
        tick(2);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        wait_strobes("sb_kernel_wait", 1'b0, KW, 100);
        wait_strobes("sb_input_wait", 1'b1, IW, 200);
        pulses(OW, 1);
        finish_run("start_busy", OW, 0);

        // Strobe while idle.
        tick(2);
        pulses(1, 0);
        tick(1);
        chk("idle_strobe_error", 32'(error), 1);
        chk("idle_strobe_no_count", 32'(out_count), OW);
        chk("idle_not_busy", 32'(busy), 0);

        // Reset in the middle of the input stream, then a clean run.
        start_run("midreset", 1'b0);
        wait_strobes("mr_kernel_wait", 1'b0, KW, 100);
        pulses(3, 0);
        tick(5);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk_reset_outputs("midreset");
            tick(1);
        end
        src_q.delete();
        rst_n = 1'b1;
        tick(3);
        start_run("post_reset", 1'b0);
        wait_strobes("pr_kernel_wait", 1'b0, KW, 100);
        wait_strobes("pr_input_wait", 1'b1, IW, 200);
        pulses(OW, 1);
        finish_run("post_reset", OW, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
